debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
UART-side debug/control stage that sits directly upstream of cpu_top's clock enable and downstream of the UART byte receiver and transmitter.
- Decodes single-byte host commands to run, single-step or dump the BIP-I CPU.
- Gates CPU execution through o_cpu_en.
- Serialises a PC/ACC/cycle-count snapshot back to the host over the UART transmit byte interface.

Parameters:
PC_W, 11, CPU program counter width (must be ≤16)
ACC_W, 16, CPU accumulator width (must be ≤16)
CNT_W, 16, executed-cycle counter width (must be ≤16)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-low
i_rx_data  in  8  received command byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, new byte on i_rx_data
i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
o_tx_data  out  8  byte to transmit
o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
i_halt  in  1  CPU has executed HLT (level)
i_pc  in  PC_W  CPU program counter
i_acc  in  ACC_W  CPU accumulator
o_cpu_en  out  1  CPU clock enable
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE; cycle counter=0; snapshot registers=0.
  - o_tx_data=0, o_tx_start=0, o_cpu_en=0, o_busy=0.
  - Applies mid-run or mid-frame; the frame is abandoned and o_tx_start drops immediately.
- States: IDLE, RUN, STEP, SEND, WAIT_TX.
- Commands are accepted only in IDLE on i_rx_done=1. Any byte received in another state is dropped. Unknown bytes are ignored and leave the unit in IDLE.
  - 0x52 'R': if i_halt=1, go to SEND. Else go to RUN.
  - 0x53 'S': if i_halt=1, go to SEND. Else go to STEP.
  - 0x44 'D': go to SEND.
  - 0x43 'C': clear the cycle counter; stay in IDLE; nothing is transmitted.
- o_cpu_en is combinational: (state==RUN && !i_halt) || state==STEP.
- Cycle counter:
  - Increments on every cycle with o_cpu_en=1.
  - Saturates at 2^CNT_W-1; no wrap.
- RUN: stays in RUN while i_halt=0. On the first cycle with i_halt=1, go to SEND; o_cpu_en is already 0 in that cycle.
- STEP: lasts exactly one cycle (o_cpu_en=1 for one cycle), then go to SEND.
- Snapshot: on every transition into SEND, i_pc, i_acc and the counter are latched. For STEP, the latch happens on the cycle after the enable, so the snapshot reflects the post-step values.
- Frame: 6 bytes, big-endian, each field zero-extended to 16 bits.
  - Order: PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
- SEND: drives o_tx_data=byte[idx], pulses o_tx_start for one cycle, then goes to WAIT_TX.
- WAIT_TX:
  - o_tx_data is held stable until i_tx_done.
  - On i_tx_done: if the last byte was sent, go to IDLE and clear idx. Else increment idx and return to SEND.
  - i_tx_done received outside WAIT_TX is ignored.
- Frame rate: start pulses are therefore at least 2 cycles apart; a full frame costs ≥12 cycles.
- Simultaneous i_rx_done and i_tx_done in WAIT_TX: the tx_done is processed and the rx byte is dropped.

Optional Feature:
DEBUG_UNIT_CHECKSUM_EN:
- Defined: a 7th byte is appended, equal to the XOR of the 6 frame bytes. The frame ends after this 7th i_tx_done.
- Undefined: the frame is exactly 6 bytes and no checksum logic is synthesised.

Test Plan:
- Reset: hold i_rst=0 while i_rx_done pulses with 0x52 -> o_cpu_en=0, o_tx_start=0, o_busy=0 throughout; after release, state is IDLE and the counter is 0.
- Step: i_pc=0x005, i_acc=0x1234 after step, send 'S' -> o_cpu_en high exactly 1 cycle, then frame 00 05 12 34 00 01 (checksum 0x22 when the macro is defined).
- Run to halt: send 'R', raise i_halt after 7 enabled cycles with i_pc=0x7FF, i_acc=0xFFFF -> o_cpu_en falls the same cycle as i_halt; frame 07 FF FF FF 00 07.
- Halted CPU: with i_halt=1, send 'R' -> o_cpu_en never asserts; frame is sent immediately with CNT unchanged. Then send 'C', then 'D' -> CNT bytes are 00 00.
- Command during transmit: send 'D', then pulse 'S' during WAIT_TX -> o_cpu_en stays 0; exactly 6 (or 7) o_tx_start pulses; unit returns to IDLE.
- Unknown byte 0x41 in IDLE -> no o_tx_start, no o_cpu_en, o_busy stays 0. Counter saturation with CNT_W=4: run 20 cycles, then dump -> CNT low byte 0x0F.

Source files
------------

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART debug/control stage for the BIP-I CPU (optional checksum byte: DEBUG_UNIT_CHECKSUM_EN)
module debug_unit #(
    parameter int PC_W  = 11,
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done,
    input  logic             i_tx_done,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    input  logic             i_halt,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [ACC_W-1:0] i_acc,
    output logic             o_cpu_en,
    output logic             o_busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_STEP    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

`ifdef DEBUG_UNIT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      pc_q, acc_q, cnt_snap_q;
    logic [15:0]      pc_v, acc_v, cnt_v;
    logic             snap_ld;
    logic [7:0]       byte_sel;

    // The snapshot is taken in the first SEND cycle rather than on the edge
    // into SEND, so a single step is reported with its post-step PC/ACC.
    // The live values are bypassed onto the frame for that one cycle.
    assign snap_ld = (state_q == S_SEND) && (idx_q == 3'd0);
    assign pc_v    = snap_ld ? 16'(i_pc)  : pc_q;
    assign acc_v   = snap_ld ? 16'(i_acc) : acc_q;
    assign cnt_v   = snap_ld ? 16'(cnt_q) : cnt_snap_q;

    assign o_cpu_en   = ((state_q == S_RUN) && !i_halt) || (state_q == S_STEP);
    assign o_busy     = (state_q != S_IDLE);
    assign o_tx_start = (state_q == S_SEND);
    assign o_tx_data  = byte_sel;

    // Big-endian frame byte selected by idx
    always_comb begin
        case (idx_q)
            3'd0:    byte_sel = pc_v[15:8];
            3'd1:    byte_sel = pc_v[7:0];
            3'd2:    byte_sel = acc_v[15:8];
            3'd3:    byte_sel = acc_v[7:0];
            3'd4:    byte_sel = cnt_v[15:8];
`ifdef DEBUG_UNIT_CHECKSUM_EN
            3'd5:    byte_sel = cnt_v[7:0];
            default: byte_sel = pc_v[15:8] ^ pc_v[7:0] ^ acc_v[15:8] ^ acc_v[7:0]
                              ^ cnt_v[15:8] ^ cnt_v[7:0];
`else
            default: byte_sel = cnt_v[7:0];
`endif
        endcase
    end

    // Command decode, run/step control, frame sequencing and the saturating counter
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (o_cpu_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        8'h52:   state_d = i_halt ? S_SEND : S_RUN;
                        8'h53:   state_d = i_halt ? S_SEND : S_STEP;
                        8'h44:   state_d = S_SEND;
                        8'h43:   cnt_d   = '0;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_SEND;
                end
            end
            S_STEP:  state_d = S_SEND;
            S_SEND:  state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, index and counter registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Snapshot registers, loaded once per frame and held until the next frame
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q       <= 16'h0000;
            acc_q      <= 16'h0000;
            cnt_snap_q <= 16'h0000;
        end else if (snap_ld) begin
            pc_q       <= pc_v;
            acc_q      <= acc_v;
            cnt_snap_q <= cnt_v;
        end
    end
endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - randomized and directed check of debug_unit against a frame-level model
module tb_debug_unit;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_STEP = 2;
    localparam int MODE_TX   = 3;
`ifdef DEBUG_UNIT_CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        halt = 1'b0;
    logic [10:0] pc = 11'h000;
    logic [15:0] acc = 16'h0000;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_start_a, tx_start_b, en_a, en_b, busy_a, busy_b;

    always #5 clk = ~clk;

    debug_unit dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .o_tx_data(tx_data_a), .o_tx_start(tx_start_a),
        .i_halt(halt), .i_pc(pc), .i_acc(acc), .o_cpu_en(en_a), .o_busy(busy_a)
    );

    debug_unit #(.CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .o_tx_data(tx_data_b), .o_tx_start(tx_start_b),
        .i_halt(halt), .i_pc(pc), .i_acc(acc), .o_cpu_en(en_b), .o_busy(busy_b)
    );

    int          vectors = 0;
    int          errors = 0;
    int          mode = MODE_IDLE;
    int          k = 0;
    bit          inflight = 1'b0;
    int          cnt = 0;
    bit          exp_en = 1'b0;
    bit          rand_cpu = 1'b0;
    logic [10:0] post_pc = 11'h000;
    logic [15:0] post_acc = 16'h0000;
    logic [47:0] snap_a = '0;
    logic [47:0] snap_b = '0;
    logic [7:0]  got_a[$];
    logic [7:0]  got_b[$];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [47:0] f, input int i);
        logic [7:0] x = 8'h00;
        if (i < 6) return f[47-8*i -: 8];
        for (int j = 0; j < 6; j++) x ^= f[47-8*j -: 8];
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = MODE_IDLE;
        k = 0;
        inflight = 1'b0;
        cnt = 0;
    endtask

    // Expected outputs for the current cycle, compared against both instances
    task automatic check();
        bit exp_start, exp_busy;
        if (mode == MODE_TX && k == 0 && !inflight) begin
            snap_a = {16'(pc), acc, 16'(sat(cnt, 65535))};
            snap_b = {16'(pc), acc, 16'(sat(cnt, 15))};
        end
        exp_en    = (mode == MODE_RUN && !halt) || mode == MODE_STEP;
        exp_start = (mode == MODE_TX) && !inflight;
        exp_busy  = (mode != MODE_IDLE);
        cmp("cpu_en_a", 32'(en_a), 32'(exp_en));
        cmp("cpu_en_b", 32'(en_b), 32'(exp_en));
        cmp("busy_a", 32'(busy_a), 32'(exp_busy));
        cmp("busy_b", 32'(busy_b), 32'(exp_busy));
        cmp("tx_start_a", 32'(tx_start_a), 32'(exp_start));
        cmp("tx_start_b", 32'(tx_start_b), 32'(exp_start));
        if (mode == MODE_TX) begin
            cmp("tx_data_a", 32'(tx_data_a), 32'(frame_byte(snap_a, k)));
            cmp("tx_data_b", 32'(tx_data_b), 32'(frame_byte(snap_b, k)));
        end
        if (tx_start_a) got_a.push_back(tx_data_a);
        if (tx_start_b) got_b.push_back(tx_data_b);
    endtask

    // Model transition on the active edge using the inputs held across it
    task automatic advance();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (exp_en) cnt++;
        case (mode)
            MODE_IDLE: if (rx_done) begin
                case (rx_data)
                    8'h52:   mode = halt ? MODE_TX : MODE_RUN;
                    8'h53:   mode = halt ? MODE_TX : MODE_STEP;
                    8'h44:   mode = MODE_TX;
                    8'h43:   cnt = 0;
                    default: ;
                endcase
                k = 0;
                inflight = 1'b0;
            end
            MODE_RUN:  if (halt) mode = MODE_TX;
            MODE_STEP: mode = MODE_TX;
            default: begin
                if (!inflight) inflight = 1'b1;
                else if (tx_done) begin
                    inflight = 1'b0;
                    k++;
                    if (k == NBYTES) begin
                        mode = MODE_IDLE;
                        k = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic tick();
        bit was_en;
        @(negedge clk);
        check();
        was_en = exp_en;
        @(posedge clk);
        advance();
        #1;
        if (was_en) begin
            pc  = rand_cpu ? 11'($urandom) : post_pc;
            acc = rand_cpu ? 16'($urandom) : post_acc;
        end
        rx_done = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic respond();
        if (mode == MODE_TX && inflight && $urandom_range(0, 2) == 0) tx_done = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (mode != MODE_IDLE && n < limit) begin
            respond();
            tick();
            n++;
        end
        if (mode != MODE_IDLE) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, limit);
        end
    endtask

    task automatic run_enabled(input int n_en);
        int n = 0;
        int guard = 0;
        while (n < n_en && guard < 200) begin
            tick();
            if (exp_en) n++;
            guard++;
        end
    endtask

    task automatic expect_frame(input string name, input logic [47:0] fa, input logic [7:0] ca,
                                input logic [47:0] fb, input logic [7:0] cb);
        logic [7:0] ea, eb;
        cmp({name, "_len_a"}, 32'(got_a.size()), 32'(NBYTES));
        cmp({name, "_len_b"}, 32'(got_b.size()), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            ea = (i < 6) ? fa[47-8*i -: 8] : ca;
            eb = (i < 6) ? fb[47-8*i -: 8] : cb;
            if (i < got_a.size()) cmp($sformatf("%s_a[%0d]", name, i), 32'(got_a[i]), 32'(ea));
            if (i < got_b.size()) cmp($sformatf("%s_b[%0d]", name, i), 32'(got_b[i]), 32'(eb));
        end
        got_a.delete();
        got_b.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while a run command arrives
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'h52;
            rx_done = 1'b1;
            tick();
        end
        cmp("rst_tx_data", 32'(tx_data_a), 32'h0);
        rst_n = 1'b1;
        tick();
        got_a.delete();
        got_b.delete();

        // Dump straight after reset: everything zero
        send_cmd(8'h44);
        wait_idle("dump0", 100);
        expect_frame("dump0", 48'h0000_0000_0000, 8'h00, 48'h0000_0000_0000, 8'h00);

        // Single step with post-step PC/ACC
        post_pc = 11'h005;
        post_acc = 16'h1234;
        send_cmd(8'h53);
        wait_idle("step", 100);
        expect_frame("step", 48'h0005_1234_0001, 8'h22, 48'h0005_1234_0001, 8'h22);

        // Run to halt after 7 enabled cycles
        send_cmd(8'h43);
        post_pc = 11'h7FF;
        post_acc = 16'hFFFF;
        send_cmd(8'h52);
        run_enabled(7);
        halt = 1'b1;
        wait_idle("run", 100);
        expect_frame("run", 48'h07FF_FFFF_0007, 8'hFF, 48'h07FF_FFFF_0007, 8'hFF);

        // Halted CPU: run command dumps immediately, then clear and dump
        send_cmd(8'h52);
        wait_idle("halted", 100);
        expect_frame("halted", 48'h07FF_FFFF_0007, 8'hFF, 48'h07FF_FFFF_0007, 8'hFF);
        send_cmd(8'h43);
        send_cmd(8'h44);
        wait_idle("clr", 100);
        expect_frame("clr", 48'h07FF_FFFF_0000, 8'hF8, 48'h07FF_FFFF_0000, 8'hF8);

        // Commands arriving while the frame is being transmitted
        halt = 1'b0;
        send_cmd(8'h44);
        for (int n = 0; n < 20 && !(mode == MODE_TX && inflight); n++) tick();
        rx_data = 8'h53;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        for (int n = 0; n < 20 && !(mode == MODE_TX && inflight); n++) tick();
        rx_data = 8'h53;
        rx_done = 1'b1;
        tick();
        wait_idle("busy_cmd", 200);
        expect_frame("busy_cmd", 48'h07FF_FFFF_0000, 8'hF8, 48'h07FF_FFFF_0000, 8'hF8);

        // Unknown byte is ignored
        send_cmd(8'h41);
        for (int i = 0; i < 3; i++) tick();
        cmp("unknown_starts", 32'(got_a.size()), 32'h0);

        // Counter saturation on the 4-bit instance after 20 enabled cycles
        post_pc = 11'h123;
        post_acc = 16'hABCD;
        send_cmd(8'h52);
        run_enabled(20);
        halt = 1'b1;
        wait_idle("sat", 100);
        expect_frame("sat", 48'h0123_ABCD_0014, 8'h50, 48'h0123_ABCD_000F, 8'h4B);

        // Asynchronous reset in the middle of a frame
        send_cmd(8'h44);
        tick();
        respond();
        tick();
        tx_done = 1'b1;
        tick();
        for (int n = 0; n < 10 && !(mode == MODE_TX && !inflight); n++) begin
            respond();
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_start", 32'(tx_start_a), 32'h0);
        cmp("async_rst_busy", 32'(busy_a), 32'h0);
        model_reset();
        tick();
        rst_n = 1'b1;
        got_a.delete();
        got_b.delete();

        // Randomized traffic
        rand_cpu = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            respond();
            if (!tx_done && $urandom_range(0, 9) == 0) tx_done = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                rx_done = 1'b1;
                case ($urandom_range(0, 5))
                    0: rx_data = 8'h52;
                    1: rx_data = 8'h53;
                    2: rx_data = 8'h44;
                    3: rx_data = 8'h43;
                    4: rx_data = 8'h41;
                    default: rx_data = 8'($urandom);
                endcase
            end
            if (mode == MODE_RUN) begin
                if ($urandom_range(0, 11) == 0) halt = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                halt = ~halt;
            end
            if (mode == MODE_IDLE && $urandom_range(0, 3) == 0) begin
                pc = 11'($urandom);
                acc = 16'($urandom);
            end
            tick();
        end
        rx_done = 1'b0;
        wait_idle("random_drain", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
